// File: rtl/mdu_if.sv
// Request/result bundle for the multiply/divide unit: operation request
// (start/mdop/srcA/srcB) and the architectural HI/LO state with busy.
interface mdu_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdop, srcA, srcB, input busy, hi, lo);
  modport slave  (input start, mdop, srcA, srcB, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; fixed-latency down-counter.
// Optional accumulate ops (madd/maddu) are built only with MDU_MADD_EN defined.
//
// state | meaning
// IDLE  | ready for a request, busy=0; mthi/mtlo complete here
// RUN   | mult/div in flight, counter holds remaining cycles
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          mul_req, div_req, accept, done;
  logic [63:0]   prod_s, prod_u, res;
  logic          res_wr;

  always_comb begin
    mul_req = (bus.mdop == OP_MULT) || (bus.mdop == OP_MULTU);
`ifdef MDU_MADD_EN
    mul_req = mul_req || (bus.mdop == OP_MADD) || (bus.mdop == OP_MADDU);
`endif
    div_req = (bus.mdop == OP_DIV) || (bus.mdop == OP_DIVU);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && mul_req) begin
          accept    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = CW'(MULT_CYCLES);
        end else if (bus.start && div_req) begin
          accept    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Low 64 bits of the sign-extended product equal the signed product mod 2^64.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  always_comb begin
    res    = {hi_q, lo_q};
    res_wr = 1'b0;
    case (op_q)
      OP_MULT:  begin res = prod_s; res_wr = 1'b1; end
      OP_MULTU: begin res = prod_u; res_wr = 1'b1; end
      OP_DIV: begin
        if (b_q != 32'b0) begin
          res_wr = 1'b1;
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)
            res = {32'b0, 32'h8000_0000};
          else
            res = {32'($signed(a_q) % $signed(b_q)), 32'($signed(a_q) / $signed(b_q))};
        end
      end
      OP_DIVU: begin
        if (b_q != 32'b0) begin
          res_wr = 1'b1;
          res    = {a_q % b_q, a_q / b_q};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res = {hi_q, lo_q} + prod_s; res_wr = 1'b1; end
      OP_MADDU: begin res = {hi_q, lo_q} + prod_u; res_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.mdop;
        a_q  <= bus.srcA;
        b_q  <= bus.srcB;
      end
      if (done && res_wr) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end
      if (state == IDLE && bus.start && bus.mdop == OP_MTHI) hi_q <= bus.srcA;
      if (state == IDLE && bus.start && bus.mdop == OP_MTLO) lo_q <= bus.srcA;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares when an operation completes or is sampled.
module tb_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   snap_cnt = 0;
  int   snap_seen = 0;
  int   run_len = 0;

  task automatic compare(input int len);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_output: got hi=%h lo=%h busy_len=%0d, no expectation queued",
               bus.hi, bus.lo, len);
      return;
    end
    e = exp_q.pop_front();
    checks += 3;
    if (bus.hi !== e.hi) begin
      failures++;
      $display("FAIL %s_hi: got %h expected %h", e.name, bus.hi, e.hi);
    end
    if (bus.lo !== e.lo) begin
      failures++;
      $display("FAIL %s_lo: got %h expected %h", e.name, bus.lo, e.lo);
    end
    if (len != e.cycles) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", e.name, len, e.cycles);
    end
  endtask

  // Monitor: busy falling marks a completion; otherwise honour pending snapshots.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        compare(run_len);
        run_len = 0;
      end else if (snap_seen < snap_cnt) begin
        snap_seen++;
        compare(0);
      end
    end
  end

  task automatic expect_res(input string name, input logic [31:0] h, input logic [31:0] l,
                            input int cyc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  task automatic snap(input string name, input logic [31:0] h, input logic [31:0] l);
    expect_res(name, h, l, 0);
    snap_cnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mdop = op; bus.srcA = a; bus.srcB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy === 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.busy, n);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.mdop = 3'b000; bus.srcA = 32'hDEAD_BEEF; bus.srcB = 32'h1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    snap("reset", 32'h0, 32'h0);

    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult");

    expect_res("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue(3'b001, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu");

    expect_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");

    issue(3'b100, 32'h11, 32'h0);
    snap("mthi", 32'h11, 32'hFFFF_FFFD);
    issue(3'b101, 32'h22, 32'h0);
    snap("mtlo", 32'h11, 32'h22);

    expect_res("divu_by0", 32'h11, 32'h22, 10);
    issue(3'b011, 32'd7, 32'd0);
    wait_idle("divu_by0");

    expect_res("divu", 32'd2, 32'd14, 10);
    issue(3'b011, 32'd100, 32'd7);
    wait_idle("divu");

    expect_res("div_ovf", 32'h0, 32'h8000_0000, 10);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    // mtlo attempted on busy cycle 2, operands also disturbed mid-run
    expect_res("mult_busy_start", 32'h1, 32'h0, 5);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mdop = 3'b101; bus.srcA = 32'h55; bus.srcB = 32'h9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("mult_busy_start");

    issue(3'b100, 32'h1234, 32'h0);
    snap("mthi_1234", 32'h1234, 32'h0);
    issue(3'b101, 32'h1234, 32'h0);
    snap("mtlo_1234", 32'h1234, 32'h1234);

    // reset on div cycle 3 with a mult pending; mult must land on first post-reset edge
    expect_res("rst_abort", 32'h0, 32'h0, 3);
    expect_res("mult_post_rst", 32'h0, 32'd42, 5);
    issue(3'b010, 32'h1234, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1'b1; bus.mdop = 3'b000; bus.srcA = 32'd6; bus.srcB = 32'd7;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy !== 1'b1) begin
      checks++; failures++;
      $display("FAIL post_rst_accept: busy=%b expected 1", bus.busy);
    end else begin
      checks++;
    end
    wait_idle("mult_post_rst");

    issue(3'b100, 32'h0, 32'h0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0);
    snap("madd_setup", 32'h0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    expect_res("madd", 32'h1, 32'h0, 5);
    issue(3'b110, 32'd1, 32'd1);
    wait_idle("madd");
`else
    issue(3'b110, 32'd1, 32'd1);
    snap("madd_ignored", 32'h0, 32'hFFFF_FFFF);
    issue(3'b111, 32'd1, 32'd1);
    snap("maddu_ignored", 32'h0, 32'hFFFF_FFFF);
`endif

    repeat (20) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || run_len != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d run_len=%0d expected 0 and 0", exp_q.size(), run_len);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
